// File: rtl/dpram_fifo_ctrl_2048_60bit.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl_2048_60bit
//
// Show-ahead FIFO controller in front of a 2048x60 dual-port RAM. Port A is the
// write side, fed from an upstream valid/ready stream. Port B is the read side.
// A 2-entry output buffer hides the RAM's 1-cycle registered read latency, so
// the downstream stream can move one word per cycle.
//
// Ports:
//   clk, resetn           clock (rising edge), async active-low reset
//   flush                 synchronous clear of all contents (wins over all)
//   in_valid/in_ready     upstream handshake, in_data word
//   out_valid/out_ready   downstream handshake, out_data head word (registered)
//   count                 words held: RAM + in-flight read + output buffer
//   almost_full           count >= AF_LEVEL (watermark build only, else 0)
//   address_a/wren_a/data_a   RAM port A (write)
//   address_b/wren_b/data_b   RAM port B (read; wren_b/data_b tied to 0)
//   out_b                 RAM port B read data, valid 1 cycle after address_b
//
// Build option: define DPRAM_FIFO_WATERMARK_EN to enable the registered
// almost_full flag; otherwise almost_full is tied to 0.
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl_2048_60bit #(
  parameter int unsigned AWIDTH    = 11,
  parameter int unsigned NUM_WORDS = 2048,
  parameter int unsigned DWIDTH    = 60,
  parameter int unsigned AF_LEVEL  = 1792
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic [AWIDTH-1:0] address_a,
  output logic              wren_a,
  output logic [DWIDTH-1:0] data_a,
  output logic [AWIDTH-1:0] address_b,
  output logic              wren_b,
  output logic [DWIDTH-1:0] data_b,
  input  logic [DWIDTH-1:0] out_b
);

  localparam logic [AWIDTH:0] LP_NUM_WORDS = NUM_WORDS[AWIDTH:0];
  localparam logic [AWIDTH:0] LP_AF_LEVEL  = AF_LEVEL[AWIDTH:0];

  // State
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_ram_cnt;
  logic              r_inflight;
  logic [1:0]        r_buf_occ;
  logic [DWIDTH-1:0] r_buf0;     // head
  logic [DWIDTH-1:0] r_buf1;

  // Next-state / combinational
  logic              w_push;
  logic              w_pop;
  logic              w_fetch;
  logic [2:0]        w_pending;
  logic [1:0]        w_occ_after_pop;
  logic [AWIDTH:0]   w_ram_cnt_nxt;
  logic [1:0]        w_buf_occ_nxt;
  logic              w_inflight_nxt;
  logic [DWIDTH-1:0] w_buf0_nxt;
  logic [DWIDTH-1:0] w_buf1_nxt;

  assign in_ready  = !flush && (r_ram_cnt < LP_NUM_WORDS);
  assign w_push    = in_valid && in_ready;
  assign out_valid = (r_buf_occ != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // Words already headed for the buffer once this cycle's pop is taken out.
  // pop implies buf_occ >= 1, so this never underflows.
  assign w_pending = {1'b0, r_buf_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // ram_cnt only counts words whose write edge has passed, so a fetched slot
  // is never the one being written this cycle.
  assign w_fetch   = !flush && (r_ram_cnt != '0) && (w_pending < 3'd2);

  assign wren_a    = w_push;
  assign address_a = r_wr_ptr;
  assign data_a    = in_data;

  assign address_b = r_rd_ptr;
  assign wren_b    = 1'b0;
  assign data_b    = '0;

  assign out_data  = r_buf0;
  assign count     = r_ram_cnt + (AWIDTH+1)'(r_inflight) + (AWIDTH+1)'(r_buf_occ);

  assign w_occ_after_pop = r_buf_occ - {1'b0, w_pop};

  always_comb begin
    w_ram_cnt_nxt  = r_ram_cnt;
    w_buf_occ_nxt  = r_buf_occ;
    w_inflight_nxt = w_fetch;
    w_buf0_nxt     = r_buf0;
    w_buf1_nxt     = r_buf1;
    if (flush) begin
      w_ram_cnt_nxt  = '0;
      w_buf_occ_nxt  = 2'd0;
      w_inflight_nxt = 1'b0;
      w_buf0_nxt     = '0;
      w_buf1_nxt     = '0;
    end else begin
      unique case ({w_push, w_fetch})
        2'b10:   w_ram_cnt_nxt = r_ram_cnt + 1'b1;
        2'b01:   w_ram_cnt_nxt = r_ram_cnt - 1'b1;
        default: w_ram_cnt_nxt = r_ram_cnt;
      endcase
      // Popping a full buffer shifts the second entry to the head.
      if (w_pop && (r_buf_occ == 2'd2)) begin
        w_buf0_nxt = r_buf1;
      end
      // Returning read data lands in the first free slot after the pop.
      if (r_inflight) begin
        if (w_occ_after_pop == 2'd0) begin
          w_buf0_nxt = out_b;
        end else begin
          w_buf1_nxt = out_b;
        end
      end
      w_buf_occ_nxt = w_occ_after_pop + {1'b0, r_inflight};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_buf_occ  <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push)  r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
        if (w_fetch) r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
      end
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_inflight <= w_inflight_nxt;
      r_buf_occ  <= w_buf_occ_nxt;
      r_buf0     <= w_buf0_nxt;
      r_buf1     <= w_buf1_nxt;
    end
  end

`ifdef DPRAM_FIFO_WATERMARK_EN
  // Registered from the next-state count so the flag lines up with count.
  logic            r_almost_full;
  logic [AWIDTH:0] w_count_nxt;

  assign w_count_nxt = w_ram_cnt_nxt + (AWIDTH+1)'(w_inflight_nxt)
                     + (AWIDTH+1)'(w_buf_occ_nxt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_nxt >= LP_AF_LEVEL);
    end
  end

  assign almost_full = r_almost_full;
`else
  logic w_unused_af;
  assign w_unused_af = ^LP_AF_LEVEL;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl_2048_60bit.sv
// ---------------------------------------------------------------------------
// tb_dpram_fifo_ctrl_2048_60bit
//
// Self-checking bench for dpram_fifo_ctrl_2048_60bit with a behavioural
// 2048x60 RAM. A directed vector table covers reset, single-word latency and a
// flush with a read in flight; a queue-based reference model then checks
// streaming, full, random backpressure and flush sequences cycle by cycle.
// ---------------------------------------------------------------------------
module tb_dpram_fifo_ctrl_2048_60bit;

  localparam int AW = 11;
  localparam int DW = 60;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic [AW-1:0] address_a;
  logic          wren_a;
  logic [DW-1:0] data_a;
  logic [AW-1:0] address_b;
  logic          wren_b;
  logic [DW-1:0] data_b;
  logic [DW-1:0] out_b;

  dpram_fifo_ctrl_2048_60bit dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .address_a   (address_a),
    .wren_a      (wren_a),
    .data_a      (data_a),
    .address_b   (address_b),
    .wren_b      (wren_b),
    .data_b      (data_b),
    .out_b       (out_b)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered read on port B.
  logic [DW-1:0] ram [0:2047];
  always @(posedge clk) begin
    if (wren_a) ram[address_a] <= data_a;
    out_b <= ram[address_b];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents in order.
  logic [DW-1:0] q[$];
  logic          s_ov;
  logic          s_ir;
  logic [DW-1:0] s_od;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  // One clock cycle: drive, sample at negedge, check against model, advance.
  task automatic cycle(input logic fl, input logic iv, input logic [DW-1:0] d,
                       input logic ordy);
    logic push;
    logic pop;
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    s_ov = out_valid; s_ir = in_ready; s_od = out_data;
    chk("count", 64'(count), 64'(q.size()));
    if (q.size() == 0) chk("ov_when_empty", 64'(out_valid), 64'(0));
    else if (out_valid) chk("head_data", 64'(out_data), 64'(q[0]));
    if (hold_prev) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'(out_data), 64'(hold_data));
    end
    if (fl) chk("ir_flush", 64'(in_ready), 64'(0));
    else if (q.size() < 2048) chk("ir_room", 64'(in_ready), 64'(1));
    else if (q.size() >= 2050) chk("ir_full", 64'(in_ready), 64'(0));
    push = iv && in_ready;
    chk("wren_a", 64'(wren_a), 64'(push));
    if (push) chk("data_a", 64'(data_a), 64'(d));
    chk("port_b_write", 64'({wren_b, data_b}), 64'(0));
`ifdef DPRAM_FIFO_WATERMARK_EN
    chk("almost_full", 64'(almost_full), 64'(q.size() >= 1792));
`else
    chk("almost_full_off", 64'(almost_full), 64'(0));
`endif
    pop       = out_valid && ordy;
    hold_prev = out_valid && !ordy && !fl;
    hold_data = out_data;
    @(posedge clk); #1;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
  endtask

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    int            e_cnt;
    logic          e_ir;
    logic          e_wren;
    int            e_aa;
  } vec_t;

  vec_t vt[14];

  initial begin
    int nrecv;
    int sent;
    int n;
    logic got;
    logic iv_r;
    logic or_r;
    logic [DW-1:0] d_r;

    // Single word (0..4), then push 3 and flush with a read in flight (5..8),
    // then a fresh word 5 must be the first out (9..13).
    vt[0]  = '{0, 1, 60'hABC, 1, 0, 0,        0, 1, 1, 0};
    vt[1]  = '{0, 0, 0,       1, 0, 0,        1, 1, 0, 1};
    vt[2]  = '{0, 0, 0,       1, 0, 0,        1, 1, 0, 1};
    vt[3]  = '{0, 0, 0,       1, 1, 60'hABC,  1, 1, 0, 1};
    vt[4]  = '{0, 0, 0,       1, 0, 0,        0, 1, 0, 1};
    vt[5]  = '{0, 1, 60'h11,  0, 0, 0,        0, 1, 1, 1};
    vt[6]  = '{0, 1, 60'h22,  0, 0, 0,        1, 1, 1, 2};
    vt[7]  = '{0, 1, 60'h33,  0, 0, 0,        2, 1, 1, 3};
    vt[8]  = '{1, 1, 60'h44,  1, 1, 60'h11,   3, 0, 0, 4};
    vt[9]  = '{0, 1, 60'h5,   1, 0, 0,        0, 1, 1, 0};
    vt[10] = '{0, 0, 0,       1, 0, 0,        1, 1, 0, 1};
    vt[11] = '{0, 0, 0,       1, 0, 0,        1, 1, 0, 1};
    vt[12] = '{0, 0, 0,       1, 1, 60'h5,    1, 1, 0, 1};
    vt[13] = '{0, 0, 0,       1, 0, 0,        0, 1, 0, 1};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_almost_full", 64'(almost_full), 64'(0));
    chk("rst_wren_a", 64'(wren_a), 64'(0));
    chk("rst_address_a", 64'(address_a), 64'(0));
    chk("rst_address_b", 64'(address_b), 64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      flush = vt[i].fl; in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
      if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vt[i].e_od));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_ir));
      chk($sformatf("vec%0d_wren_a", i), 64'(wren_a), 64'(vt[i].e_wren));
      chk($sformatf("vec%0d_address_a", i), 64'(address_a), 64'(vt[i].e_aa));
      @(posedge clk); #1;
    end

    // Streaming 4096 words: in order, no gaps once the first word appears.
    nrecv = 0;
    for (int i = 0; i < 4096 + 20; i++) begin
      if (i < 4096) cycle(1'b0, 1'b1, DW'(i), 1'b1);
      else          cycle(1'b0, 1'b0, '0, 1'b1);
      if (nrecv > 0 && nrecv < 4096) chk("stream_gap", 64'(s_ov), 64'(1));
      if (s_ov) nrecv++;
    end
    chk("stream_words", 64'(nrecv), 64'(4096));

    // Fill with out_ready low until in_ready drops.
    for (int i = 0; i < 2100; i++) begin
      cycle(1'b0, 1'b1, {28'($urandom), 32'($urandom)}, 1'b0);
      if (!s_ir) break;
    end
    chk("full_accepted", 64'(q.size()), 64'(2050));
    chk("full_count", 64'(count), 64'(2050));
    cycle(1'b0, 1'b0, '0, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      if (s_ir) begin
        got = 1'b1;
        break;
      end
    end
    chk("refill_ready", 64'(got), 64'(1));
    for (int i = 0; i < 2200 && q.size() > 0; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    chk("full_drain", 64'(q.size()), 64'(0));

    // Random backpressure, 1000 words.
    sent = 0;
    n = 0;
    while (sent < 1000 && n < 6000) begin
      iv_r = ($urandom_range(0, 3) != 0);
      or_r = $urandom_range(0, 1) != 0;
      d_r  = {28'($urandom), 32'($urandom)};
      cycle(1'b0, iv_r, d_r, or_r);
      if (iv_r && s_ir) sent++;
      n++;
    end
    chk("rand_sent", 64'(sent), 64'(1000));
    for (int i = 0; i < 2200 && q.size() > 0; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    chk("rand_drain", 64'(q.size()), 64'(0));

    // Flush mid-stream while a read is in flight.
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, DW'(100 + i), 1'b1);
    cycle(1'b1, 1'b1, 60'hDEAD, 1'b1);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    cycle(1'b0, 1'b1, 60'h5, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (s_ov) begin
        got = 1'b1;
        chk("flush_first_word", 64'(s_od), 64'(60'h5));
        break;
      end
    end
    chk("flush_word_seen", 64'(got), 64'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
